// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, word width.
package lsu_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_RD   = 4'b0010,
      ST_WR   = 4'b0100,
      ST_RSP  = 4'b1000
   } state_e;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling: load extract with sign/zero extension and store merge into a fetched word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   input  logic [1:0]        i_lo,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_load,
   output logic [WORD_W-1:0] o_store
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte  = i_word[{i_lo, 3'b000} +: 8];
      w_half  = i_word[{i_lo[1], 4'b0000} +: 16];
      o_load  = i_word;
      o_store = i_wdata;
      case (i_size)
         SZ_B: begin
            o_load  = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            o_store = i_word;
            o_store[{i_lo, 3'b000} +: 8] = i_wdata[7:0];
         end
         SZ_H: begin
            o_load  = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            o_store = i_word;
            o_store[{i_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: begin
            o_load  = i_word;
            o_store = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per request, sub-word stores via read-modify-write.
//   state | meaning
//   IDLE  | ready for a request, errors decided here
//   RD    | one-cycle memory read, word captured
//   WR    | one-cycle memory write (full or merged word)
//   RSP   | one-cycle response pulse
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata
);

   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   state_e            r_state, w_next;
   logic              r_we, r_uns, r_err;
   size_e             r_size;
   logic [WORD_W-1:0] r_addr, r_wdata, r_word;
   logic              w_accept, w_err;
   logic [WORD_W-1:0] w_load, w_store;

   assign w_accept = (r_state == ST_IDLE) && req_valid;
   assign w_err    = (req_size == SZ_X) || misaligned(req_size, req_addr[1:0])
                     || (req_addr[31:2] >= DEPTH_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_err   <= 1'b0;
         r_size  <= SZ_B;
         r_addr  <= '0;
         r_wdata <= '0;
         r_word  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_err   <= w_err;
            r_size  <= size_e'(req_size);
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (r_state == ST_RD) begin
            r_word <= mem_rdata;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_err)                            w_next = ST_RSP;
               else if (req_we && req_size == SZ_W)  w_next = ST_WR;
               else                                  w_next = ST_RD;
            end
         end
         ST_RD:   w_next = r_we ? ST_WR : ST_RSP;
         ST_WR:   w_next = ST_RSP;
         ST_RSP:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   lsu_align u_align (
      .i_word     (r_word),
      .i_lo       (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .i_wdata    (r_wdata),
      .o_load     (w_load),
      .o_store    (w_store)
   );

   // All strobes and response fields decode from registered state so reset clears them at once.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         ST_IDLE: req_ready = 1'b1;
         ST_RD: begin
            mem_read = 1'b1;
            mem_addr = {2'b00, r_addr[31:2]};
         end
         ST_WR: begin
            mem_write = 1'b1;
            mem_addr  = {2'b00, r_addr[31:2]};
            mem_wdata = w_store;
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            rsp_err   = r_err;
            rsp_rdata = (r_err || r_we) ? '0 : w_load;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 64-word data memory.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err, mem_read, mem_write;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [64];
   logic        pre_en = 1'b0;
   logic [5:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;

   int   cyc = 0;
   int   n_cmp = 0, n_bad = 0;
   int   n_rd = 0, n_wr = 0;
   logic [31:0] last_waddr = '0;
   exp_t q[$];

   load_store_unit #(.DEPTH(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (mem_write && mem_addr < 64) mem[mem_addr[5:0]] <= mem_wdata;
   end
   assign mem_rdata = (mem_read && mem_addr < 64) ? mem[mem_addr[5:0]] : 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mem_read && mem_write) chk("strobe_overlap", 32'd1, 32'd0);
      if (mem_read) n_rd++;
      if (mem_write) begin
         n_wr++;
         last_waddr = mem_addr;
      end
      if (rsp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            chk("rsp_latency", cyc - e.acc, e.lat);
         end
      end
   end

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat,
                        output int acc);
      int   n;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc;
      e.rdata = er; e.err = ee; e.lat = lat; e.acc = cyc;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drop();
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("rsp_timeout", q.size(), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, a3, r0, w0;

      #12;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_flags", {28'b0, rsp_valid, rsp_err, mem_read, mem_write}, 32'd0);
      chk("rst_buses", mem_addr | mem_wdata | rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      preload(6'd1, 32'h01010101);
      preload(6'd2, 32'h11223344);
      preload(6'd8, 32'h80FF7F01);
      preload(6'd12, 32'h55667788);

      // Word store then load
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, a0); drop();
      wait_done();
      chk("sw_addr", last_waddr, 32'd4);
      chk("sw_mem", mem[4], 32'hDEADBEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, a0); drop();
      wait_done();

      // Sub-word loads
      issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2, a0); drop();
      issue(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h00000080, 1'b0, 2, a0); drop();
      issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2, a0); drop();
      issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2, a0); drop();
      issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000007F, 1'b0, 2, a0); drop();
      wait_done();

      // Read-modify-write stores
      r0 = n_rd; w0 = n_wr;
      issue(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AA, 32'h0, 1'b0, 3, a0); drop();
      wait_done();
      chk("sb_mem", mem[2], 32'h1122AA44);
      chk("sb_reads", n_rd - r0, 32'd1);
      chk("sb_writes", n_wr - w0, 32'd1);
      r0 = n_rd; w0 = n_wr;
      issue(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF, 32'h0, 1'b0, 3, a0); drop();
      wait_done();
      chk("sh_mem", mem[2], 32'hBEEFAA44);
      chk("sh_reads", n_rd - r0, 32'd1);
      chk("sh_writes", n_wr - w0, 32'd1);

      // Error responses
      r0 = n_rd; w0 = n_wr;
      issue(1'b0, 2'b10, 1'b0, 32'h6,   32'h0, 32'h0, 1'b1, 1, a0); drop();
      issue(1'b0, 2'b01, 1'b0, 32'h5,   32'h0, 32'h0, 1'b1, 1, a0); drop();
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0, 1'b1, 1, a0); drop();
      issue(1'b1, 2'b11, 1'b0, 32'h4,   32'hCAFEF00D, 32'h0, 1'b1, 1, a0); drop();
      wait_done();
      chk("err_reads", n_rd - r0, 32'd0);
      chk("err_writes", n_wr - w0, 32'd0);
      chk("err_mem1", mem[1], 32'h01010101);
      chk("err_mem4", mem[4], 32'hDEADBEEF);

      // Reset during the write phase of a byte store
      issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h000000EE, 32'h0, 1'b0, 3, a0); drop();
      @(negedge clk);
      @(negedge clk);
      chk("rmw_in_wr", {31'b0, mem_write}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_write", {30'b0, mem_write, mem_read}, 32'd0);
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_mid_mem", mem[12], 32'h55667788);

      // Back-to-back with req_valid held high
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, a0);
      issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000005A, 32'h0, 1'b0, 3, a1);
      issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h0000005A, 1'b0, 2, a2);
      issue(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, 1, a3);
      drop();
      wait_done();
      chk("b2b_gap1", a1 - a0, 32'd3);
      chk("b2b_gap2", a2 - a1, 32'd4);
      chk("b2b_gap3", a3 - a2, 32'd3);
      chk("b2b_mem8", mem[8], 32'h80FF7F5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
